// File: rtl/a2d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : a2d_pkg
// Purpose  : Shared types and constants for the A2D scan sequencer.
// Revision : 1.0  initial release
// ============================================================================
package a2d_pkg;

    // Upper bound on scanned slots; also sets the slot index width (3 bits).
    localparam int MAX_CH = 8;

    // Low-order filler of the A2D command word below the channel field.
    localparam logic [10:0] CMD_PAD = 11'h000;

    // Conversion FSM: two SPI transactions per sample (select, then read back).
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_WAIT1  = 3'd2,
        S_GAP    = 3'd3,
        S_READ   = 3'd4,
        S_WAIT2  = 3'd5,
        S_ACC    = 3'd6,
        S_UPDATE = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/a2d_avg_acc.sv
`default_nettype none
// ============================================================================
// Module   : a2d_avg_acc
// Purpose  : Sample accumulator and sample counter for 2^AVG_LOG2 averaging.
// Revision : 1.0  initial release
// ============================================================================
module a2d_avg_acc #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_add,
    input  logic                       i_inc,
    input  logic [DATA_W-1:0]          i_din,
    output logic [DATA_W+AVG_LOG2-1:0] o_acc,
    output logic                       o_full
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    // A zero-width counter is not legal, so keep one bit that never counts.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    // Accumulate samples and count them; clear takes priority once a result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            if (i_add)
                r_acc <= r_acc + ACC_W'(i_din);
            if (i_inc && !o_full)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_full = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/a2d_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : a2d_scan_seq
// Purpose  : Round-robin A2D channel scanner with per-slot result registers,
//            optional sample averaging and single-step / free-run modes.
// Revision : 1.0  initial release
// ============================================================================
module a2d_scan_seq #(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     nxt,
    input  logic                     scan_mode,
    input  logic [3*NUM_CH-1:0]      ch_map,
    output logic                     wrt,
    output logic [15:0]              cmd,
    input  logic                     done,
    input  logic [15:0]              rsp,
    output logic [DATA_W*NUM_CH-1:0] result,
    output logic [NUM_CH-1:0]        res_vld,
    output logic                     scan_done,
    output logic                     busy
);
    import a2d_pkg::*;

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam logic [2:0] c_last_slot = 3'(NUM_CH - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [2:0]                r_slot;
    logic [2:0]                w_slot_inc;
    logic [2:0]                w_lat_slot;
    logic [2:0]                r_ch_q;
    logic [2:0]                w_ch_sel;
    logic                      w_go;
    logic                      w_latch;
    logic                      w_acc_full;
    logic [ACC_W-1:0]          w_acc;
    logic [DATA_W*NUM_CH-1:0]  r_result;
    logic [NUM_CH-1:0]         r_res_vld;
    logic                      w_unused;

    // Upper response bits above the result width carry nothing we need.
    assign w_unused = ^rsp[15:DATA_W];

    assign w_go       = nxt | scan_mode;
    assign w_slot_inc = (r_slot == c_last_slot) ? 3'd0 : r_slot + 3'd1;
    // From IDLE the current slot starts; from UPDATE the following slot starts.
    assign w_lat_slot = (r_state == S_UPDATE) ? w_slot_inc : r_slot;
    assign w_latch    = ((r_state == S_IDLE) && w_go) ||
                        ((r_state == S_UPDATE) && scan_mode);

    // Select the channel number mapped to the slot about to be converted.
    always_comb begin
        w_ch_sel = 3'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_lat_slot == 3'(i))
                w_ch_sel = ch_map[3*i +: 3];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; done is only honoured while a transaction is pending.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_go) w_state_nxt = S_CMD;
            S_CMD:    w_state_nxt = S_WAIT1;
            S_WAIT1:  if (done) w_state_nxt = S_GAP;
            S_GAP:    w_state_nxt = S_READ;
            S_READ:   w_state_nxt = S_WAIT2;
            S_WAIT2:  if (done) w_state_nxt = S_ACC;
            S_ACC:    w_state_nxt = w_acc_full ? S_UPDATE : S_CMD;
            S_UPDATE: w_state_nxt = scan_mode ? S_CMD : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; the command word follows the latched channel.
    always_comb begin
        wrt       = (r_state == S_CMD) || (r_state == S_READ);
        busy      = (r_state != S_IDLE);
        scan_done = (r_state == S_UPDATE) && (r_slot == c_last_slot);
        cmd       = {2'b00, r_ch_q, CMD_PAD};
    end

    // Slot pointer advances on each update; channel is latched at slot start only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= 3'd0;
            r_ch_q <= 3'd0;
        end else begin
            if (r_state == S_UPDATE)
                r_slot <= w_slot_inc;
            if (w_latch)
                r_ch_q <= w_ch_sel;
        end
    end

    a2d_avg_acc #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state == S_UPDATE),
        .i_add  ((r_state == S_WAIT2) && done),
        .i_inc  (r_state == S_ACC),
        .i_din  (rsp[DATA_W-1:0]),
        .o_acc  (w_acc),
        .o_full (w_acc_full)
    );

    // Store the averaged (truncated) result into the slot being updated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_res_vld <= '0;
        end else if (r_state == S_UPDATE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_slot == 3'(i)) begin
                    r_result[DATA_W*i +: DATA_W] <= w_acc[ACC_W-1:AVG_LOG2];
                    r_res_vld[i]                 <= 1'b1;
                end
            end
        end
    end

    assign result  = r_result;
    assign res_vld = r_res_vld;

endmodule
`default_nettype wire

// File: tb/tb_a2d_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_a2d_scan_seq
// Purpose  : Directed self-checking bench for a2d_scan_seq (3-slot plain and
//            1-slot 4x-averaging instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_a2d_scan_seq;

    localparam logic [8:0] MAP0    = {3'd4, 3'd5, 3'd0};
    localparam logic [8:0] MAP_MID = {3'd4, 3'd5, 3'd7};

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        nxt, scan_mode, done;
    logic [8:0]  ch_map;
    logic [15:0] rsp;
    logic        wrt_a, scan_done_a, busy_a;
    logic [15:0] cmd_a;
    logic [35:0] result_a;
    logic [2:0]  res_vld_a;

    logic        nxt_b, scan_mode_b, done_b;
    logic [2:0]  ch_map_b;
    logic [15:0] rsp_b;
    logic        wrt_b, scan_done_b, busy_b;
    logic [15:0] cmd_b;
    logic [11:0] result_b;
    logic [0:0]  res_vld_b;

    int n_vec   = 0;
    int n_err   = 0;
    int n_wrt_b = 0;

    logic        sd;
    logic [35:0] res_upd;
    logic [15:0] vals_b [4];

    always #5 clk = ~clk;

    a2d_scan_seq #(.NUM_CH(3), .DATA_W(12), .AVG_LOG2(0)) u_dut_a (
        .clk(clk), .rst(rst), .nxt(nxt), .scan_mode(scan_mode), .ch_map(ch_map),
        .wrt(wrt_a), .cmd(cmd_a), .done(done), .rsp(rsp), .result(result_a),
        .res_vld(res_vld_a), .scan_done(scan_done_a), .busy(busy_a)
    );

    a2d_scan_seq #(.NUM_CH(1), .DATA_W(12), .AVG_LOG2(2)) u_dut_b (
        .clk(clk), .rst(rst), .nxt(nxt_b), .scan_mode(scan_mode_b), .ch_map(ch_map_b),
        .wrt(wrt_b), .cmd(cmd_b), .done(done_b), .rsp(rsp_b), .result(result_b),
        .res_vld(res_vld_b), .scan_done(scan_done_b), .busy(busy_b)
    );

    // Count SPI transaction starts on the averaging instance.
    always @(negedge clk) begin
        if (wrt_b) n_wrt_b <= n_wrt_b + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One full conversion on instance A, entered at the negedge of its CMD cycle
    // and left at the negedge after UPDATE.
    task automatic conv_a(input string tag, input logic [15:0] exp_cmd,
                          input logic [15:0] val, input logic [8:0] map_mid,
                          input logic sm_mid, input logic nxt_in_wait,
                          output logic sd_o, output logic [35:0] res_o);
        chk({tag, "_wrt1"}, 64'(wrt_a), 64'd1);
        chk({tag, "_cmd1"}, 64'(cmd_a), 64'(exp_cmd));
        @(negedge clk);                       // WAIT1
        ch_map    = map_mid;
        scan_mode = sm_mid;
        if (nxt_in_wait) begin
            nxt = 1'b1;
            @(negedge clk);
            nxt = 1'b0;
            chk({tag, "_nxt_ign"}, 64'({wrt_a, busy_a}), 64'd1);
        end
        done = 1'b1;
        rsp  = ~val;                          // first response must be discarded
        @(negedge clk);                       // GAP
        done = 1'b0;
        rsp  = 16'h0000;
        chk({tag, "_gap"}, 64'(wrt_a), 64'd0);
        @(negedge clk);                       // READ
        chk({tag, "_wrt2"}, 64'(wrt_a), 64'd1);
        chk({tag, "_cmd2"}, 64'(cmd_a), 64'(exp_cmd));
        @(negedge clk);                       // WAIT2
        done = 1'b1;
        rsp  = val;
        @(negedge clk);                       // ACC
        done = 1'b0;
        rsp  = 16'h0000;
        @(negedge clk);                       // UPDATE
        sd_o  = scan_done_a;
        res_o = result_a;
        @(negedge clk);
    endtask

    initial begin
        nxt = 0; scan_mode = 0; done = 0; rsp = 0; ch_map = MAP0;
        nxt_b = 0; scan_mode_b = 0; done_b = 0; rsp_b = 0; ch_map_b = 3'd6;
        vals_b = '{16'd100, 16'd101, 16'd102, 16'd105};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_result", 64'(result_a), 64'd0);
        chk("rst_vld",    64'(res_vld_a), 64'd0);
        chk("rst_wrt",    64'(wrt_a), 64'd0);
        chk("rst_cmd",    64'(cmd_a), 64'd0);
        chk("rst_sdone",  64'(scan_done_a), 64'd0);
        chk("rst_busy",   64'(busy_a), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy_a), 64'd0);

        // Single steps over all three slots
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        conv_a("s0", 16'h0000, 16'h0ABC, MAP0, 1'b0, 1'b0, sd, res_upd);
        chk("s0_sd", 64'(sd), 64'd0);
        chk("s0_lat", 64'(res_upd), 64'd0);
        chk("s0_res", 64'(result_a), 64'h000_000_ABC);
        chk("s0_vld", 64'(res_vld_a), 64'b001);
        chk("s0_busy", 64'(busy_a), 64'd0);

        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        conv_a("s1", 16'h2800, 16'hF123, MAP0, 1'b0, 1'b0, sd, res_upd);
        chk("s1_sd", 64'(sd), 64'd0);
        chk("s1_res", 64'(result_a), 64'h000_123_ABC);
        chk("s1_vld", 64'(res_vld_a), 64'b011);

        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        conv_a("s2", 16'h2000, 16'h0FFF, MAP0, 1'b0, 1'b0, sd, res_upd);
        chk("s2_sd", 64'(sd), 64'd1);
        chk("s2_res", 64'(result_a), 64'hFFF_123_ABC);
        chk("s2_vld", 64'(res_vld_a), 64'b111);

        // Free-run: two full scans back to back, then stop mid-slot 1
        scan_mode = 1'b1;
        @(negedge clk);
        conv_a("c1_0", 16'h0000, 16'h0111, MAP0, 1'b1, 1'b0, sd, res_upd);
        chk("c1_0_sd", 64'(sd), 64'd0);
        conv_a("c1_1", 16'h2800, 16'h0222, MAP0, 1'b1, 1'b0, sd, res_upd);
        chk("c1_1_sd", 64'(sd), 64'd0);
        conv_a("c1_2", 16'h2000, 16'h0333, MAP0, 1'b1, 1'b0, sd, res_upd);
        chk("c1_2_sd", 64'(sd), 64'd1);
        conv_a("c2_0", 16'h0000, 16'h0444, MAP0, 1'b1, 1'b0, sd, res_upd);
        chk("c2_0_sd", 64'(sd), 64'd0);
        conv_a("c2_1", 16'h2800, 16'h0555, MAP0, 1'b1, 1'b0, sd, res_upd);
        chk("c2_1_sd", 64'(sd), 64'd0);
        conv_a("c2_2", 16'h2000, 16'h0666, MAP0, 1'b1, 1'b0, sd, res_upd);
        chk("c2_2_sd", 64'(sd), 64'd1);
        chk("c2_res", 64'(result_a), 64'h666_555_444);
        conv_a("c3_0", 16'h0000, 16'h0777, MAP_MID, 1'b1, 1'b0, sd, res_upd);
        chk("c3_0_sd", 64'(sd), 64'd0);
        conv_a("c3_1", 16'h2800, 16'h0888, MAP0, 1'b0, 1'b0, sd, res_upd);
        chk("c3_1_sd", 64'(sd), 64'd0);
        chk("c3_res", 64'(result_a), 64'h666_888_777);
        chk("c3_idle", 64'({busy_a, wrt_a}), 64'd0);

        // Spurious done in IDLE
        done = 1'b1;
        rsp  = 16'h0555;
        @(negedge clk);
        done = 1'b0;
        rsp  = 16'h0000;
        @(negedge clk);
        chk("spur_idle", 64'({busy_a, wrt_a}), 64'd0);
        chk("spur_res", 64'(result_a), 64'h666_888_777);

        // nxt during WAIT1 is neither honoured nor queued
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        conv_a("nw", 16'h2000, 16'h0999, MAP0, 1'b0, 1'b1, sd, res_upd);
        chk("nw_sd", 64'(sd), 64'd1);
        chk("nw_res", 64'(result_a), 64'h999_888_777);
        @(negedge clk);
        chk("nw_noq", 64'({busy_a, wrt_a}), 64'd0);

        // Reset during WAIT2 of slot 1
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        conv_a("r0", 16'h0000, 16'h0AAA, MAP0, 1'b0, 1'b0, sd, res_upd);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        chk("r1_cmd", 64'(cmd_a), 64'h2800);
        @(negedge clk);                       // WAIT1
        done = 1'b1;
        @(negedge clk);                       // GAP
        done = 1'b0;
        @(negedge clk);                       // READ
        @(negedge clk);                       // WAIT2
        rst = 1'b1;
        #1;
        chk("arst_wrt", 64'(wrt_a), 64'd0);
        chk("arst_res", 64'(result_a), 64'd0);
        chk("arst_vld", 64'(res_vld_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        done = 1'b1;
        rsp  = 16'h0FFF;
        @(negedge clk);
        done = 1'b0;
        rsp  = 16'h0000;
        @(negedge clk);
        chk("late_done", 64'({busy_a, wrt_a, res_vld_a}), 64'd0);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        conv_a("rs", 16'h0000, 16'h0321, MAP0, 1'b0, 1'b0, sd, res_upd);
        chk("rs_res", 64'(result_a), 64'h000_000_321);
        chk("rs_vld", 64'(res_vld_a), 64'b001);

        // Instance B: one slot, four samples averaged
        nxt_b = 1'b1;
        @(negedge clk);
        nxt_b = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("b%0d_wrt", s), 64'(wrt_b), 64'd1);
            chk($sformatf("b%0d_cmd", s), 64'(cmd_b), 64'h3000);
            @(negedge clk);                   // WAIT1
            done_b = 1'b1;
            rsp_b  = 16'h0FFF;
            @(negedge clk);                   // GAP
            done_b = 1'b0;
            rsp_b  = 16'h0000;
            @(negedge clk);                   // READ
            @(negedge clk);                   // WAIT2
            done_b = 1'b1;
            rsp_b  = vals_b[s];
            @(negedge clk);                   // ACC
            done_b = 1'b0;
            rsp_b  = 16'h0000;
            @(negedge clk);                   // CMD again, or UPDATE after the last
        end
        chk("b_sdone", 64'(scan_done_b), 64'd1);
        chk("b_lat", 64'(result_b), 64'd0);
        @(negedge clk);
        chk("b_res", 64'(result_b), 64'd102);
        chk("b_vld", 64'(res_vld_b), 64'd1);
        chk("b_idle", 64'(busy_b), 64'd0);
        chk("b_nwrt", 64'(n_wrt_b), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/a2d_scan_seq.md
Name: a2d_scan_seq

Overview:
- Parametrised successor to the fixed three-channel A2D round-robin: scans NUM_CH configurable A2D channels and keeps one result register per channel.
- Optional 2^AVG_LOG2 sample averaging per channel.
- Either single-step (advanced by nxt from the digital core) or free-running scan mode.
- Drives a word-level SPI master through a wrt/done transaction handshake. Sits between the digital core and the A2D SPI master.

Parameters:
- NUM_CH, 3, channels scanned (1..8).
- DATA_W, 12, result width taken from rsp[DATA_W-1:0].
- AVG_LOG2, 0, log2 of samples averaged per result (0..3).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- nxt  in  1  single-step request: convert the current channel, then advance
- scan_mode  in  1  1 = free-run continuous scan; 0 = step on nxt only
- ch_map  in  3*NUM_CH  A2D channel number for slot i, at bits [3i+2:3i]
- wrt  out  1  one-cycle pulse: start SPI transaction with cmd
- cmd  out  16  SPI command word
- done  in  1  SPI master transaction complete (one-cycle pulse)
- rsp  in  16  SPI word received, valid when done=1
- result  out  DATA_W*NUM_CH  per-slot result, slot i at [DATA_W*(i+1)-1:DATA_W*i]
- res_vld  out  NUM_CH  slot i holds at least one completed result
- scan_done  out  1  one-cycle pulse when the last slot updates
- busy  out  1  conversion in progress (state != IDLE)

Behaviour:
- Reset (async, rst=1):
  - state IDLE, slot=0, sample count=0, accumulators=0.
  - result all 0, res_vld 0, wrt 0, cmd 16'h0000, scan_done 0.
  - Assertion mid-transaction abandons it. A done arriving after reset release with nothing pending is ignored.
- FSM states: IDLE, CMD, WAIT1, GAP, READ, WAIT2, ACC, UPDATE.
- IDLE:
  - Go to CMD when nxt=1 or scan_mode=1.
  - ch_map slot bits are latched into ch_q on this transition.
- CMD:
  - wrt=1 for exactly one cycle, cmd = {2'b00, ch_q, 11'h000}.
  - Next state WAIT1.
- WAIT1: wait for done; rsp is discarded. Next state GAP.
- GAP: one idle cycle (wrt=0), guaranteeing the A2D SS_n gap. Next state READ.
- READ: wrt=1 for one cycle with the same cmd. Next state WAIT2.
- WAIT2: on done, add rsp[DATA_W-1:0] into a (DATA_W+AVG_LOG2)-bit accumulator. Next state ACC.
- ACC:
  - If sample count < 2^AVG_LOG2 - 1: increment the count and go to CMD (same slot, ch_q unchanged).
  - Otherwise go to UPDATE.
- UPDATE (one cycle):
  - result[slot] <= acc >> AVG_LOG2 (truncating); res_vld[slot] <= 1.
  - Clear the accumulator and sample count.
  - slot <= (slot == NUM_CH-1) ? 0 : slot+1.
  - scan_done=1 in this cycle when slot was NUM_CH-1.
  - Next state: CMD if scan_mode=1 (ch_map for the new slot latched here), else IDLE.
- Latencies:
  - nxt sampled in IDLE -> first wrt pulse the next cycle.
  - Second done -> result visible 2 cycles later (ACC, then UPDATE registered).
- Boundaries:
  - nxt while busy is ignored, not queued.
  - done outside WAIT1/WAIT2 is ignored.
  - scan_mode falling mid-conversion: the current slot completes and updates, then the FSM returns to IDLE.
  - ch_map changing mid-conversion has no effect until the next slot latch.
  - NUM_CH=1: slot stays 0 and scan_done pulses on every UPDATE.
  - AVG_LOG2=0: ACC passes straight to UPDATE. Sum of 8 samples at 12'hFFF fits in 15 bits, so no overflow.
  - result and res_vld are registered outputs, glitch-free.

Decomposition:
- Shared package a2d_pkg holds:
  - state enum;
  - CMD_PAD = 11'h000;
  - helper constant MAX_CH = 8.
- One sub-module: a2d_avg_acc (accumulator + sample counter, with clr/add/full outputs), parametrised by DATA_W and AVG_LOG2.

Test Plan:
- Reset release with NUM_CH=3, ch_map={3'd4,3'd5,3'd0} -> all outputs 0; nxt pulse -> wrt at the next cycle with cmd=16'h0000; second wrt carries the same cmd; done with rsp=16'h0ABC -> result[0]=12'hABC two cycles after the second done, res_vld=3'b001.
- Three nxt steps -> cmd sequence 16'h0000, 16'h2800, 16'h2000 (2 wrt each); scan_done pulses exactly once, on the slot-2 update; slot wraps to 0.
- AVG_LOG2=2, rsp 100, 101, 102, 105 on successive second-dones -> 8 wrt pulses, then result[0]=102 (408>>2).
- scan_mode=1 held for two full scans -> back-to-back conversions with no IDLE cycle, two scan_done pulses; deassert scan_mode mid-slot-1 -> slot 1 updates, then IDLE, busy=0.
- nxt pulsed during WAIT1, and spurious done in IDLE -> no extra wrt, state and results unchanged.
- rst asserted during WAIT2 -> wrt=0, result=0, res_vld=0 immediately; late done after release is ignored, and the next nxt restarts at slot 0.
